// File: rtl/bcd_hms_if.sv
// bcd_hms_if: control and status bundle between the lab-clock sequencer and the hh:mm:ss counter
interface bcd_hms_if;
  logic tick;
  logic up;
  logic clr;
  logic load;
  logic [23:0] load_val;
  logic [23:0] bcd_out;
  logic tc;
  logic done;
  logic load_err;
  modport master(output tick, up, clr, load, load_val, input bcd_out, tc, done, load_err);
  modport slave(input tick, up, clr, load, load_val, output bcd_out, tc, done, load_err);
endinterface

// File: rtl/bcd_hms_counter.sv
// bcd_hms_counter: six-digit BCD hh:mm:ss up/down counter with preset, clear and wrap/saturate
module bcd_hms_counter #(
  parameter int HOUR_MAX = 23,
  parameter bit WRAP = 1'b1
) (
  input logic clk,
  input logic rst,
  bcd_hms_if.slave bus
);
  localparam logic [3:0] HM1 = 4'(HOUR_MAX / 10);
  localparam logic [3:0] HM0 = 4'(HOUR_MAX % 10);
  localparam logic [23:0] TOP = {HM1, HM0, 16'h5959};
  localparam logic [23:0] LIM = 24'h995959;
  logic [23:0] r_val;
  logic r_tc, r_done, r_err;
  logic [23:0] w_nxt;
  logic w_bnd, w_legal;
  always_comb begin
    logic c;
    logic [3:0] d, l;
    c = 1'b1;
    w_nxt = r_val;
    w_legal = bus.load_val[7:4] <= 4'd5 && bus.load_val[15:12] <= 4'd5 && bus.load_val[23:16] <= {HM1, HM0};
    for (int i = 0; i < 6; i++) begin
      d = r_val[4*i+:4];
      l = LIM[4*i+:4];
      w_nxt[4*i+:4] = !c ? d : bus.up ? (d == l ? 4'd0 : d + 4'd1) : (d == 4'd0 ? l : d - 4'd1);
      c = c && (bus.up ? d == l : d == 4'd0);
      w_legal = w_legal && bus.load_val[4*i+:4] <= 4'd9;
    end
    w_bnd = bus.up ? r_val == TOP : r_val == 24'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= '0;
      r_tc <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      r_err <= 1'b0;
      if (bus.clr) begin
        r_val <= '0;
        r_done <= 1'b0;
      end else if (bus.load) begin
        if (w_legal) begin
          r_val <= bus.load_val;
          r_done <= 1'b0;
        end else r_err <= 1'b1;
      end else if (bus.tick) begin
        if (!w_bnd) begin
          r_val <= w_nxt;
          r_done <= 1'b0;
        end else if (WRAP) begin
          r_val <= bus.up ? 24'd0 : TOP;
          r_tc <= 1'b1;
        end else if (!r_done) begin
          r_tc <= 1'b1;
          r_done <= 1'b1;
        end
      end
    end
  end
  assign bus.bcd_out = r_val;
  assign bus.tc = r_tc;
  assign bus.done = r_done;
  assign bus.load_err = r_err;
endmodule

// File: tb/tb_bcd_hms_counter.sv
// tb_bcd_hms_counter: three parameterisations driven in lockstep against a seconds-based reference model
module tb_bcd_hms_counter;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  logic clk, rst, tick, up, clr, load;
  logic [23:0] load_val;
  int n_cmp = 0, n_bad = 0;
  bcd_hms_if b0 ();
  bcd_hms_if b1 ();
  bcd_hms_if b2 ();
  assign {b0.tick, b0.up, b0.clr, b0.load, b0.load_val} = {tick, up, clr, load, load_val};
  assign {b1.tick, b1.up, b1.clr, b1.load, b1.load_val} = {tick, up, clr, load, load_val};
  assign {b2.tick, b2.up, b2.clr, b2.load, b2.load_val} = {tick, up, clr, load, load_val};
  logic [2:0][26:0] o;
  assign o[0] = {b0.bcd_out, b0.tc, b0.done, b0.load_err};
  assign o[1] = {b1.bcd_out, b1.tc, b1.done, b1.load_err};
  assign o[2] = {b2.bcd_out, b2.tc, b2.done, b2.load_err};
  bcd_hms_counter #(.HOUR_MAX(23), .WRAP(1'b1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  bcd_hms_counter #(.HOUR_MAX(12), .WRAP(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  bcd_hms_counter #(.HOUR_MAX(23), .WRAP(1'b0)) u2 (.clk(clk), .rst(rst), .bus(b2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int hm[3] = '{23, 12, 23};
  bit wr[3] = '{1'b1, 1'b1, 1'b0};
  int m_secs[3] = '{0, 0, 0};
  bit m_done[3], m_tc[3], m_err[3];
  function automatic logic [23:0] to_bcd(int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
  function automatic int from_bcd(logic [23:0] v);
    return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 + (int'(v[15:12]) * 10 + int'(v[11:8])) * 60
           + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction
  function automatic bit legal(int hmax, logic [23:0] v);
    for (int i = 0; i < 6; i++) if (v[4*i+:4] > 4'd9) return 1'b0;
    if (v[7:4] > 4'd5 || v[15:12] > 4'd5) return 1'b0;
    return int'(v[23:20]) * 10 + int'(v[19:16]) <= hmax;
  endfunction
  task automatic step(input int k);
    int top;
    top = (hm[k] + 1) * 3600 - 1;
    m_tc[k] = 1'b0;
    m_err[k] = 1'b0;
    if (rst || clr) begin
      m_secs[k] = 0;
      m_done[k] = 1'b0;
    end else if (load) begin
      if (legal(hm[k], load_val)) begin
        m_secs[k] = from_bcd(load_val);
        m_done[k] = 1'b0;
      end else m_err[k] = 1'b1;
    end else if (tick) begin
      if ((up && m_secs[k] == top) || (!up && m_secs[k] == 0)) begin
        if (wr[k]) begin
          m_secs[k] = up ? 0 : top;
          m_tc[k] = 1'b1;
        end else if (!m_done[k]) begin
          m_tc[k] = 1'b1;
          m_done[k] = 1'b1;
        end
      end else begin
        m_secs[k] += up ? 1 : -1;
        m_done[k] = 1'b0;
      end
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) step(k);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d bcd_out", k), 32'(o[k][26:3]), 32'(to_bcd(m_secs[k])));
      chk($sformatf("u%0d tc", k), 32'(o[k][2]), 32'(m_tc[k]));
      chk($sformatf("u%0d done", k), 32'(o[k][1]), 32'(m_done[k]));
      chk($sformatf("u%0d load_err", k), 32'(o[k][0]), 32'(m_err[k]));
    end
  endtask
  task automatic drive(input bit r, input bit c, input bit ld, input bit t, input bit u, input logic [23:0] lv);
    {rst, clr, load, tick, up, load_val} = {r, c, ld, t, u, lv};
  endtask
  typedef struct {
    bit rst, clr, load, tick, up;
    logic [23:0] lv, bcd;
    bit tc, err;
  } vec_t;
  vec_t tbl[14];
  int tc_seen;
  initial begin
    drive(H, L, L, L, H, 24'h0);
    tbl[0] = '{H, L, L, L, H, 24'h000000, 24'h000000, L, L};
    tbl[1] = '{L, L, H, L, H, 24'h235959, 24'h235959, L, L};
    tbl[2] = '{L, L, L, H, H, 24'h000000, 24'h000000, H, L};
    tbl[3] = '{L, L, L, H, L, 24'h000000, 24'h235959, H, L};
    tbl[4] = '{L, L, H, L, H, 24'h100000, 24'h100000, L, L};
    tbl[5] = '{L, L, L, H, L, 24'h000000, 24'h095959, L, L};
    tbl[6] = '{L, L, H, L, H, 24'h240000, 24'h095959, L, H};
    tbl[7] = '{L, L, H, L, H, 24'h006000, 24'h095959, L, H};
    tbl[8] = '{L, L, H, L, H, 24'h00000A, 24'h095959, L, H};
    tbl[9] = '{L, L, H, L, H, 24'h123456, 24'h123456, L, L};
    tbl[10] = '{L, H, H, H, H, 24'h235959, 24'h000000, L, L};
    tbl[11] = '{L, L, H, L, H, 24'h000059, 24'h000059, L, L};
    tbl[12] = '{L, L, L, H, H, 24'h000000, 24'h000100, L, L};
    tbl[13] = '{H, L, H, H, H, 24'h235959, 24'h000000, L, L};
    cycle();
    chk("reset bcd_out", 32'(o[0][26:3]), 32'h0);
    chk("reset flags", 32'(o[0][2:0]), 32'h0);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].load, tbl[i].tick, tbl[i].up, tbl[i].lv);
      cycle();
      chk($sformatf("vec%0d bcd_out", i), 32'(o[0][26:3]), 32'(tbl[i].bcd));
      chk($sformatf("vec%0d tc", i), 32'(o[0][2]), 32'(tbl[i].tc));
      chk($sformatf("vec%0d load_err", i), 32'(o[0][0]), 32'(tbl[i].err));
    end
    drive(H, L, L, L, H, 24'h0);
    cycle();
    tc_seen = 0;
    drive(L, L, L, H, H, 24'h0);
    for (int i = 0; i < 3600; i++) begin
      cycle();
      tc_seen += int'(o[0][2]);
    end
    chk("3600 ticks bcd_out", 32'(o[0][26:3]), 32'h010000);
    chk("3600 ticks tc count", 32'(tc_seen), 32'h0);
    drive(L, L, H, L, H, 24'h125959);
    cycle();
    drive(L, L, L, H, H, 24'h0);
    cycle();
    chk("hmax12 wrap bcd_out", 32'(o[1][26:3]), 32'h000000);
    chk("hmax12 wrap tc", 32'(o[1][2]), 32'h1);
    drive(L, L, H, L, L, 24'h000001);
    cycle();
    drive(L, L, L, H, L, 24'h0);
    cycle();
    chk("sat tick1 bcd_out", 32'(o[2][26:3]), 32'h000000);
    chk("sat tick1 tc", 32'(o[2][2]), 32'h0);
    cycle();
    chk("sat tick2 tc", 32'(o[2][2]), 32'h1);
    chk("sat tick2 done", 32'(o[2][1]), 32'h1);
    cycle();
    chk("sat tick3 tc", 32'(o[2][2]), 32'h0);
    chk("sat tick3 done", 32'(o[2][1]), 32'h1);
    chk("sat tick3 bcd_out", 32'(o[2][26:3]), 32'h000000);
    drive(L, L, L, H, H, 24'h0);
    cycle();
    chk("sat release bcd_out", 32'(o[2][26:3]), 32'h000001);
    chk("sat release done", 32'(o[2][1]), 32'h0);
    for (int n = 0; n < 3000; n++) begin
      int sel;
      rst = $urandom_range(0, 299) == 0;
      clr = $urandom_range(0, 59) == 0;
      load = $urandom_range(0, 9) == 0;
      tick = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 31) == 0) up = ~up;
      sel = int'($urandom_range(0, 5));
      load_val = sel == 0 ? 24'h235959 : sel == 1 ? 24'h125959 : sel == 2 ? 24'h000000 :
                 sel == 3 ? 24'h000001 : sel == 4 ? to_bcd(int'($urandom_range(0, 359999))) :
                 24'($urandom);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
